// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: loads a parallel pattern and shifts it out one bit
// per clock on w, with optional repeats separated by a one-cycle gap.
//
// Ports:
//   Clock    rising-edge clock
//   Resetn   synchronous active-low reset
//   start    transfer request, sampled only in IDLE
//   pattern  bits to send (low len_eff bits used)
//   len      bits per transmission (0 or >WIDTH means WIDTH)
//   rep      extra repetitions (total = rep+1)
//   w        serial data bit (0 outside SHIFT)
//   w_valid  w carries a pattern bit
//   busy     state != IDLE
//   done     one-cycle pulse after the final bit
//   ht       state code: IDLE=00 SHIFT=01 GAP=10 DONE=11
//
// Build option: SERIAL_PATTERN_LSB_FIRST_EN selects LSB-first bit order
// (default is MSB-first over the used field).
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] rep,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done,
    output logic [2:1]       ht
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] sh_q;
    logic [LEN_W-1:0] lm1_q;
    logic [LEN_W-1:0] cnt_q;
    logic [REP_W-1:0] rep_q;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] aligned;
    logic [WIDTH-1:0] sh_next;
    logic             cur_bit;
    logic             last;

    always_comb begin
        len_eff = len;
        if (len == '0 || len > LEN_W'(WIDTH)) begin
            len_eff = LEN_W'(WIDTH);
        end
    end

`ifdef SERIAL_PATTERN_LSB_FIRST_EN
    // LSB-first: bit 0 sits at the output end already.
    assign aligned = pattern;
    assign sh_next = {1'b0, sh_q[WIDTH-1:1]};
    assign cur_bit = sh_q[0];
`else
    // MSB-first: move pattern[len_eff-1] up to the top bit so the
    // register always shifts out of bit WIDTH-1.
    assign aligned = pattern << (LEN_W'(WIDTH) - len_eff);
    assign sh_next = {sh_q[WIDTH-2:0], 1'b0};
    assign cur_bit = sh_q[WIDTH-1];
`endif

    assign last = (cnt_q == '0);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        w        = 1'b0;
        w_valid  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        ht       = state_q;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                w       = cur_bit;
                w_valid = 1'b1;
                if (last) begin
                    state_nx = (rep_q == '0) ? DONE : GAP;
                end
            end
            GAP: begin
                state_nx = SHIFT;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            pat_q <= '0;
            sh_q  <= '0;
            lm1_q <= '0;
            cnt_q <= '0;
            rep_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_q <= aligned;
                        sh_q  <= aligned;
                        lm1_q <= len_eff - LEN_W'(1);
                        cnt_q <= len_eff - LEN_W'(1);
                        rep_q <= rep;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        // Reload here so the gap cycle needs no datapath work.
                        if (rep_q != '0) begin
                            rep_q <= rep_q - REP_W'(1);
                            sh_q  <= pat_q;
                            cnt_q <= lm1_q;
                        end
                    end else begin
                        sh_q  <= sh_next;
                        cnt_q <= cnt_q - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed runs plus random traffic checked
// every cycle against a per-cycle arithmetic model of the output stream.
module tb_serial_pattern_gen;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] rep = '0;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic [2:1] ht;

    int checks = 0;
    int failures = 0;

    serial_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .start(start),
        .pattern(pattern),
        .len(len),
        .rep(rep),
        .w(w),
        .w_valid(w_valid),
        .busy(busy),
        .done(done),
        .ht(ht)
    );

    always #5 Clock = ~Clock;

    function automatic int leff(logic [3:0] l);
        return (l == 0 || l > 8) ? 8 : int'(l);
    endfunction

    function automatic int busy_len(logic [3:0] l, logic [3:0] r);
        return (int'(r) + 1) * leff(l) + int'(r) + 1;
    endfunction

    // Tuple {ht, busy, done, w_valid, w} for the k-th cycle after the
    // start edge (k=1 is the first bit).
    function automatic logic [5:0] exp_at(logic [7:0] p, logic [3:0] l,
                                          logic [3:0] r, int k);
        int L = leff(l);
        int tot = busy_len(l, r);
        int k0 = k - 1;
        int i;
        int b;
        if (k < 1 || k0 >= tot) return 6'b000000;
        if (k0 == tot - 1) return 6'b111100;
        i = k0 % (L + 1);
        if (i == L) return 6'b101000;
`ifdef SERIAL_PATTERN_LSB_FIRST_EN
        b = i;
`else
        b = L - 1 - i;
`endif
        return {2'b01, 1'b1, 1'b0, 1'b1, p[b]};
    endfunction

    logic       m_act = 1'b0;
    logic [7:0] m_p = '0;
    logic [3:0] m_l = '0;
    logic [3:0] m_r = '0;
    int         m_k = 0;
    logic       chk_en = 1'b0;

    always @(posedge Clock) begin
        if (!Resetn) begin
            m_act  = 1'b0;
            m_k    = 0;
            chk_en = 1'b1;
        end else if (m_act) begin
            m_k++;
            if (m_k > busy_len(m_l, m_r)) begin
                m_act = 1'b0;
                m_k   = 0;
            end
        end else if (start) begin
            m_act = 1'b1;
            m_p   = pattern;
            m_l   = len;
            m_r   = rep;
            m_k   = 1;
        end
    end

    always @(negedge Clock) begin
        logic [5:0] e;
        logic [5:0] g;
        if (chk_en) begin
            e = m_act ? exp_at(m_p, m_l, m_r, m_k) : 6'b000000;
            g = {ht, busy, done, w_valid, w};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL cycle_model t=%0t got=%b exp=%b", $time, g, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, a, e);
        end
    endtask

    task automatic run_dir(input string name, input logic [7:0] p,
                           input logic [3:0] l, input logic [3:0] r,
                           input bit inj, input logic [31:0] exp_bits,
                           input int exp_n, input int exp_done);
        logic [31:0] bits = '0;
        int n = 0;
        int dc = 0;
        int dn = 0;
        bit ended = 0;
        @(negedge Clock);
        pattern = p;
        len = l;
        rep = r;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (c == 1) start = 1'b0;
            if (w_valid) begin
                bits = {bits[30:0], w};
                n++;
            end
            if (done) begin
                dc = c;
                dn++;
            end
            if (inj && c == 2) begin
                pattern = 8'hFF;
                start = 1'b1;
            end
            if (inj && c == 3) start = 1'b0;
            if (!busy && c > 1) begin
                ended = 1;
                break;
            end
        end
        chk({name, "_ended"}, 32'(ended), 32'd1);
        chk({name, "_nbits"}, 32'(n), 32'(exp_n));
        chk({name, "_bits"}, bits, exp_bits);
        chk({name, "_done_cycle"}, 32'(dc), 32'(exp_done));
        chk({name, "_done_count"}, 32'(dn), 32'd1);
        repeat (3) @(negedge Clock);
        chk({name, "_idle_after"}, {30'd0, ht}, 32'd0);
    endtask

    logic [5:0] pin_tab [1:10];

    initial begin
        int dn;
`ifdef SERIAL_PATTERN_LSB_FIRST_EN
        pin_tab = '{6'b011010, 6'b011011, 6'b101000, 6'b011010, 6'b011011,
                    6'b101000, 6'b011010, 6'b011011, 6'b111100, 6'b000000};
`else
        pin_tab = '{6'b011011, 6'b011010, 6'b101000, 6'b011011, 6'b011010,
                    6'b101000, 6'b011011, 6'b011010, 6'b111100, 6'b000000};
`endif
        for (int k = 1; k <= 10; k++) begin
            chk("model_pin_repeat", 32'(exp_at(8'h02, 4'd2, 4'd2, k)),
                32'(pin_tab[k]));
        end
        chk("model_pin_basic_len", 32'(busy_len(4'd3, 4'd0)), 32'd4);
        chk("model_pin_clamp", 32'(leff(4'd12)), 32'd8);

        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        chk("reset_state", {26'd0, ht, busy, done, w_valid, w}, 32'd0);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

`ifdef SERIAL_PATTERN_LSB_FIRST_EN
        run_dir("basic", 8'h03, 4'd3, 4'd0, 0, 32'b110, 3, 4);
        run_dir("repeat", 8'h02, 4'd2, 4'd2, 0, 32'b010101, 6, 9);
        run_dir("busy_ign", 8'h03, 4'd3, 4'd0, 1, 32'b110, 3, 4);
`else
        run_dir("basic", 8'h03, 4'd3, 4'd0, 0, 32'b011, 3, 4);
        run_dir("repeat", 8'h02, 4'd2, 4'd2, 0, 32'b101010, 6, 9);
        run_dir("busy_ign", 8'h03, 4'd3, 4'd0, 1, 32'b011, 3, 4);
`endif
        run_dir("clamp0", 8'hA5, 4'd0, 4'd0, 0, 32'hA5, 8, 9);
        run_dir("clamp12", 8'hA5, 4'd12, 4'd0, 0, 32'hA5, 8, 9);

        @(negedge Clock);
        pattern = 8'h02;
        len = 4'd2;
        rep = 4'd2;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        chk("rst_mid_state", {26'd0, ht, busy, done, w_valid, w}, 32'd0);
        Resetn = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge Clock);
            if (done) dn++;
        end
        chk("rst_mid_no_done", 32'(dn), 32'd0);

        repeat (3000) begin
            @(posedge Clock);
            #1;
            start = ($urandom_range(0, 3) == 0);
            pattern = 8'($urandom);
            len = 4'($urandom_range(0, 15));
            rep = 4'($urandom_range(0, 3));
            Resetn = ($urandom_range(0, 299) != 0);
        end
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        start = 1'b0;
        repeat (60) @(posedge Clock);
        @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_pattern_gen.md
Name: serial_pattern_gen

Overview:
- Serial stimulus transmitter: loads a parallel bit pattern and shifts it out one bit per clock on `w`, optionally repeating it.
- Its output is the serial input stream consumed by the team's sequence-detector FSMs (the `w` input side of those detectors).
- Sits between the bench or top-level control and any `w`-driven FSM; reports progress through `busy`, `done` and a 2-bit state debug output.

Parameters:
- WIDTH, 8, pattern register width in bits (>= 2).
- LEN_W, 4, width of `len` port; must satisfy 2**LEN_W > WIDTH.
- REP_W, 4, width of `rep` port (extra repetitions).

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  reset; synchronous, active-low, sampled on rising edge of `Clock`.
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  bits to transmit; low `len` bits are used.
- len  input  LEN_W  number of bits per transmission.
- rep  input  REP_W  additional repetitions; total transmissions = rep+1.
- w  output  1  serial data bit.
- w_valid  output  1  high while `w` carries a pattern bit.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the final bit.
- ht  output  2 [2:1]  current state code, for debug.

Behaviour:
- States (`ht` encoding): IDLE=00, SHIFT=01, GAP=10, DONE=11.
- Reset: `Resetn`=0 at a rising edge forces state to IDLE and clears all internal registers.
  - Outputs from that edge: `w`=0, `w_valid`=0, `busy`=0, `done`=0, `ht`=00.
  - Reset mid-operation aborts the transfer; no `done` pulse is produced.
- Effective length: len_eff = WIDTH if `len`=0 or `len`>WIDTH; otherwise len_eff = `len`.
- IDLE, `start`=1 at an edge: latch `pattern`, len_eff and `rep`; load the shift register; go to SHIFT.
  - First bit appears on `w` in the cycle immediately after that edge (latency 1).
- IDLE, `start`=0: remain in IDLE.
- SHIFT: `w` = current bit, `w_valid`=1. Each edge advances one bit and decrements the bit counter.
  - Bit order (default): MSB-first over the used field, i.e. pattern[len_eff-1] down to pattern[0].
  - Last bit and repeat counter = 0: go to DONE.
  - Last bit and repeat counter != 0: decrement the repeat counter, reload the shift register from the latched pattern, go to GAP.
- GAP: exactly one cycle with `w`=0 and `w_valid`=0, then SHIFT.
- DONE: `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
- `w` is forced to 0 in every state other than SHIFT.
- `start` while `busy`=1 is ignored. Input changes after the latch edge do not affect the transfer in progress.
- `start` held high: a new transfer begins on the first edge spent in IDLE after DONE. There is always at least one IDLE cycle between transfers.
- Total `busy` cycles = (rep+1)*len_eff + rep + 1.
- All outputs are combinational decodes of registered state and shift-register contents only; no path exists from inputs to outputs.

Optional Feature:
- Macro: SERIAL_PATTERN_LSB_FIRST_EN.
- Defined: bit order is LSB-first, pattern[0] up to pattern[len_eff-1]. Lengths, gaps, `done` timing and state codes are unchanged.
- Not defined: MSB-first order as in Behaviour.

Test Plan:
- Basic: WIDTH=8, `pattern`=8'h03, `len`=3, `rep`=0, `start` pulse at edge 0.
  - Expect `w` = 0,1,1 in cycles 1-3 with `w_valid`=1.
  - Expect `done`=1 only in cycle 4, `busy`=0 from cycle 5.
- Repeat: `pattern`=8'h02, `len`=2, `rep`=2.
  - Expect (`w_valid`,`w`) = (1,1),(1,0),(0,0),(1,1),(1,0),(0,0),(1,1),(1,0).
  - Expect `done` exactly once, in cycle 9.
- Length clamp: `pattern`=8'hA5 with `len`=0, then again with `len`=12.
  - Both must emit 1,0,1,0,0,1,0,1 followed by `done`.
- Ignore during busy: assert `start` with `pattern`=8'hFF in cycle 2 of the Basic run.
  - Output must be identical to the Basic run.
  - `ht` returns to 00 and no second transfer starts unless `start` is sampled in IDLE.
- Reset mid-op: drive `Resetn`=0 during cycle 2 of the Repeat run.
  - After the next edge: `ht`=00, `w`=0, `w_valid`=0, `busy`=0.
  - No `done` pulse ever appears for that run.
- Macro defined: Basic stimulus (`pattern`=8'h03, `len`=3) must emit 1,1,0 with `done` in cycle 4.
